// File: rtl/frame_capture.sv
// frame_capture: collects N audio samples into a frame buffer and hands the
// completed frame to the FFT with a valid/ready handshake.
//
// Ports
//   CLK, RST           clock, asynchronous active-high reset
//   START              one-cycle capture request
//   SAMPLE_VALID/DATA  incoming audio sample stream
//   SAMPLE_READ        sample consumed this cycle (combinational, CAPTURE only)
//   WR_EN/ADDR/DATA    registered frame-buffer write port (latency 1)
//   FRAME_VALID        frame complete, waiting for FRAME_READY
//   FRAME_READY        FFT accepts the frame
//   BUSY               capture or handoff in progress
//   FRAME_COUNT        completed-frame counter (wraps at 256)
//   DROPPED            sticky: START seen while busy
module frame_capture #(
  parameter int unsigned N  = 256,
  parameter int unsigned DW = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SAMPLE_VALID,
  input  logic [DW-1:0]        SAMPLE_DATA,
  output logic                 SAMPLE_READ,
  output logic                 WR_EN,
  output logic [$clog2(N)-1:0] WR_ADDR,
  output logic [DW-1:0]        WR_DATA,
  output logic                 FRAME_VALID,
  input  logic                 FRAME_READY,
  output logic                 BUSY,
  output logic [7:0]           FRAME_COUNT,
  output logic                 DROPPED
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    HANDOFF = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            w_accept;
  logic            w_handshake;
  logic [AW-1:0]   r_idx;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_frame_valid;
  logic            r_busy;
  logic [7:0]      r_frame_count;
  logic            r_dropped;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state and sample-accept decode
  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) w_state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (SAMPLE_VALID) begin
          w_accept = 1'b1;
          if (r_idx == LAST_IDX) w_state_nx = FLUSH;
        end
      end
      FLUSH: begin
        w_state_nx = HANDOFF;
      end
      HANDOFF: begin
        if (FRAME_READY) begin
          w_handshake = 1'b1;
          w_state_nx  = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Datapath: sample index, write port, status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx         <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= 8'd0;
      r_dropped     <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_idx;
        r_wr_data <= SAMPLE_DATA;
        // N is a power of two, so the increment wraps N-1 back to 0
        r_idx     <= r_idx + AW'(1);
      end else if (r_state == IDLE && START) begin
        r_idx <= '0;
      end
      r_frame_valid <= (w_state_nx == HANDOFF);
      r_busy        <= (w_state_nx != IDLE);
      if (w_handshake) r_frame_count <= r_frame_count + 8'd1;
      if (START && r_state != IDLE) r_dropped <= 1'b1;
    end
  end

  assign SAMPLE_READ = w_accept;
  assign WR_EN       = r_wr_en;
  assign WR_ADDR     = r_wr_addr;
  assign WR_DATA     = r_wr_data;
  assign FRAME_VALID = r_frame_valid;
  assign BUSY        = r_busy;
  assign FRAME_COUNT = r_frame_count;
  assign DROPPED     = r_dropped;

endmodule
